// File: rtl/pattern_pkg.sv
// pattern_pkg: shared FSM encodings, default sizes and named test patterns for serial pattern blocks
package pattern_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;
  localparam int WIDTH_DEF = 16;
  localparam int LEN_W_DEF = 5;
  localparam logic [2:0] PAT_111 = 3'b111;
  localparam logic [2:0] PAT_001 = 3'b001;
endpackage

// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: parallel-to-serial pattern transmitter, MSB-first, one bit per clock
//   clock/reset       rising-edge clock, synchronous active-high reset
//   in_valid/in_ready word handshake; in_data[in_len-1:0] is sent, in_len clamped to WIDTH
//   o/o_valid         registered serial bit and its qualifier
//   done              pulse with the last bit (or the cycle after a zero-length accept)
//   busy              high whenever the FSM is not idle
module serial_pattern_tx
  import pattern_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int LEN_W = LEN_W_DEF,
  parameter int GAP   = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LEN_W-1:0] in_len,
  output logic             o,
  output logic             o_valid,
  output logic             done,
  output logic             busy
);
  localparam int GW = GAP > 0 ? $clog2(GAP + 1) : 1;
  localparam logic [LEN_W-1:0] W_L = LEN_W'(WIDTH);
  logic [1:0]       state;
  logic [WIDTH-1:0] sh;
  logic [LEN_W-1:0] cnt;
  logic [GW-1:0]    gcnt;
  logic [LEN_W-1:0] len_eff;
  logic [WIDTH-1:0] aligned;
  logic             accept;
  assign in_ready = state == ST_IDLE && !reset;
  assign accept   = in_valid && in_ready;
  assign busy     = state != ST_IDLE;
  always_comb begin
    len_eff = in_len > W_L ? W_L : in_len;
    aligned = in_data << (W_L - len_eff);
  end
  // The first bit goes straight to o on accept; sh keeps the remaining bits MSB-aligned
  // and cnt counts bits still to be shown after the current one.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      sh      <= '0;
      cnt     <= '0;
      gcnt    <= '0;
      o       <= 1'b0;
      o_valid <= 1'b0;
      done    <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (accept) begin
        state   <= ST_SHIFT;
        sh      <= aligned << 1;
        cnt     <= len_eff == '0 ? '0 : len_eff - 1'b1;
        o       <= aligned[WIDTH-1];
        o_valid <= len_eff != '0;
        done    <= len_eff <= LEN_W'(1);
      end
    end else if (state == ST_SHIFT) begin
      if (cnt == '0) begin
        state   <= GAP > 0 ? ST_GAP : ST_IDLE;
        gcnt    <= GW'(GAP - 1);
        o       <= 1'b0;
        o_valid <= 1'b0;
        done    <= 1'b0;
      end else begin
        sh   <= sh << 1;
        o    <= sh[WIDTH-1];
        cnt  <= cnt - 1'b1;
        done <= cnt == LEN_W'(1);
      end
    end else begin
      state <= gcnt == '0 ? ST_IDLE : ST_GAP;
      gcnt  <= gcnt - 1'b1;
    end
  end
endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb_serial_pattern_tx: scoreboard bench for serial_pattern_tx (GAP=0 and GAP=2 instances)
module tb_serial_pattern_tx;
  import pattern_pkg::*;
  typedef struct packed {logic v; logic b; logic d;} exp_t;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic rst1, iv1, rdy1, o1, ov1, dn1, bz1;
  logic rst2, iv2, rdy2, o2, ov2, dn2, bz2;
  logic [15:0] d1, d2;
  logic [4:0] l1, l2;
  logic [2:0] hist1;
  int checks = 0;
  int errors = 0;
  exp_t q1[$];
  exp_t q2[$];
  serial_pattern_tx u1 (.clock(clock), .reset(rst1), .in_valid(iv1), .in_ready(rdy1),
    .in_data(d1), .in_len(l1), .o(o1), .o_valid(ov1), .done(dn1), .busy(bz1));
  serial_pattern_tx #(.GAP(2)) u2 (.clock(clock), .reset(rst2), .in_valid(iv2), .in_ready(rdy2),
    .in_data(d2), .in_len(l2), .o(o2), .o_valid(ov2), .done(dn2), .busy(bz2));
  task automatic chk(input string n, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %b expected %b", n, a, e);
    end
  endtask
  task automatic chkv(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask
  task automatic step;
    @(posedge clock);
    #1;
  endtask
  task automatic push(input int w, input logic [15:0] data, input logic [4:0] len);
    exp_t e;
    int le;
    le = (len > 5'd16) ? 16 : int'(len);
    if (le == 0) begin
      e = '{v: 1'b0, b: 1'b0, d: 1'b1};
      if (w == 1) q1.push_back(e); else q2.push_back(e);
    end
    for (int i = le - 1; i >= 0; i--) begin
      e = '{v: 1'b1, b: data[i], d: (i == 0)};
      if (w == 1) q1.push_back(e); else q2.push_back(e);
    end
  endtask
  task automatic wait_rdy(input int w);
    for (int i = 0; i < 100; i++) begin
      if ((w == 1) ? rdy1 : rdy2) return;
      step();
    end
    checks++;
    errors++;
    $display("FAIL wait_rdy%0d: got in_ready=0 for 100 cycles expected 1", w);
  endtask
  task automatic send(input int w, input logic [15:0] data, input logic [4:0] len);
    wait_rdy(w);
    if (w == 1) begin iv1 = 1'b1; d1 = data; l1 = len; end
    else begin iv2 = 1'b1; d2 = data; l2 = len; end
    push(w, data, len);
    step();
    if (w == 1) iv1 = 1'b0; else iv2 = 1'b0;
  endtask
  always @(negedge clock) begin
    if (!rst1) begin
      if (ov1 || dn1) begin
        if (q1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL u1_unexpected: got o_valid=%b done=%b expected no output", ov1, dn1);
        end else begin
          exp_t e;
          e = q1.pop_front();
          chk("u1_valid", ov1, e.v);
          chk("u1_bit", o1, e.b);
          chk("u1_done", dn1, e.d);
          if (ov1) hist1 = {hist1[1:0], o1};
        end
      end else chk("u1_idle_o", o1, 1'b0);
    end
  end
  always @(negedge clock) begin
    if (!rst2) begin
      if (ov2 || dn2) begin
        if (q2.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL u2_unexpected: got o_valid=%b done=%b expected no output", ov2, dn2);
        end else begin
          exp_t e;
          e = q2.pop_front();
          chk("u2_valid", ov2, e.v);
          chk("u2_bit", o2, e.b);
          chk("u2_done", dn2, e.d);
        end
      end else chk("u2_idle_o", o2, 1'b0);
    end
  end
  initial begin
    rst1 = 1'b1; rst2 = 1'b1; iv1 = 1'b1; d1 = 16'hffff; l1 = 5'd3;
    iv2 = 1'b0; d2 = '0; l2 = '0; hist1 = '0;
    step();
    step();
    @(negedge clock);
    chk("rst_rdy", rdy1, 1'b0);
    chk("rst_o", o1, 1'b0);
    chk("rst_ov", ov1, 1'b0);
    chk("rst_done", dn1, 1'b0);
    chk("rst_busy", bz1, 1'b0);
    chk("rst_rdy2", rdy2, 1'b0);
    step();
    rst1 = 1'b0; rst2 = 1'b0; iv1 = 1'b0;
    @(negedge clock);
    chk("rel_rdy", rdy1, 1'b1);
    chk("rel_rdy2", rdy2, 1'b1);
    step();
    @(negedge clock);
    chk("rst_valid_ignored_busy", bz1, 1'b0);
    // 0x0001, len 3 -> 0,0,1
    step();
    send(1, 16'h0001, 5'd3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("t1_rdy_low", rdy1, 1'b0);
      step();
    end
    @(negedge clock);
    chk("t1_rdy_high", rdy1, 1'b1);
    chkv("t1_hist_001", int'(hist1), int'(PAT_001));
    // 0x0007, len 3 -> 1,1,1
    step();
    send(1, 16'h0007, 5'd3);
    wait_rdy(1);
    @(negedge clock);
    chkv("t2_hist_111", int'(hist1), int'(PAT_111));
    // back-to-back with in_valid held: 111, idle, 1001
    step();
    wait_rdy(1);
    iv1 = 1'b1; d1 = 16'h0007; l1 = 5'd3;
    push(1, 16'h0007, 5'd3);
    step();
    d1 = 16'h0009; l1 = 5'd4;
    push(1, 16'h0009, 5'd4);
    step();
    step();
    step();
    @(negedge clock);
    chk("t3_idle_valid", ov1, 1'b0);
    chk("t3_idle_rdy", rdy1, 1'b1);
    step();
    iv1 = 1'b0;
    wait_rdy(1);
    // clamp: len 20 -> 16 bits
    step();
    send(1, 16'h8001, 5'd20);
    wait_rdy(1);
    // zero length
    step();
    send(1, 16'hffff, 5'd0);
    @(negedge clock);
    chk("t5_rdy_drop", rdy1, 1'b0);
    step();
    @(negedge clock);
    chk("t5_rdy_back", rdy1, 1'b1);
    // GAP=2 instance: word 11, two gap cycles, second word aborted by reset
    step();
    send(2, 16'h0003, 5'd2);
    step();
    step();
    @(negedge clock);
    chk("t6_gap_rdy", rdy2, 1'b0);
    chk("t6_gap_busy", bz2, 1'b1);
    chk("t6_gap_ov", ov2, 1'b0);
    step();
    @(negedge clock);
    chk("t6_gap2_rdy", rdy2, 1'b0);
    step();
    @(negedge clock);
    chk("t6_post_gap_rdy", rdy2, 1'b1);
    step();
    iv2 = 1'b1; d2 = 16'h0007; l2 = 5'd3;
    q2.push_back('{v: 1'b1, b: 1'b1, d: 1'b0});
    q2.push_back('{v: 1'b1, b: 1'b1, d: 1'b0});
    step();
    iv2 = 1'b0;
    step();
    @(negedge clock);
    #1;
    rst2 = 1'b1;
    step();
    @(negedge clock);
    chk("t6_abort_ov", ov2, 1'b0);
    chk("t6_abort_o", o2, 1'b0);
    chk("t6_abort_done", dn2, 1'b0);
    chk("t6_abort_rdy", rdy2, 1'b0);
    step();
    rst2 = 1'b0;
    @(negedge clock);
    chk("t6_release_rdy", rdy2, 1'b1);
    chk("t6_release_busy", bz2, 1'b0);
    repeat (4) step();
    chkv("q1_drained", q1.size(), 0);
    chkv("q2_drained", q2.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
